corelet_accum: RTL and testbench
================================

# corelet_accum

Parametrised accumulate/ReLU back-end for the corelet. It takes the staggered per-column partial sums leaving the MAC array and accumulates them across multiple passes in an internal psum buffer. This replaces the external L1 read-modify-write loop. After the final pass it drains aligned, optionally ReLU'd rows through a valid/ready output port toward the OFIFO or L1 writeback.

## Interface
- `col`, 8, number of array columns (lanes).
- `psum_bw`, 16, signed partial-sum width per lane.
- `depth`, 16, output rows the buffer holds per lane.
- `pass_bw`, 8, width of the pass-count field.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: launch a job; sampled only in IDLE.
- `n_pass` input pass_bw: passes to accumulate; latched at start.
- `n_out` input $clog2(depth)+1: rows per pass; latched at start and clamped to `depth`.
- `relu_en` input 1: apply ReLU on drain; latched at start.
- `in_psum` input col*psum_bw: lane c at bits [c*psum_bw +: psum_bw].
- `in_valid` input col: per-lane strobe; lanes are independent and may be staggered.
- `out_data` output col*psum_bw: one aligned row.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer accepts the row.
- `busy` output 1: high in ACCUM or DRAIN.
- `done` output 1: one-cycle pulse at job end.
- `err` output 1: sticky until reset or the next accepted start.

## Operation
- **FSM states:** IDLE, ACCUM, DRAIN.
- **Reset:**
  - State goes to IDLE.
  - `out_valid`, `busy`, `done`, `err` go to 0, and `out_data` goes to 0.
  - All pointers and counters clear.
  - Buffer contents are don't-care.
- **IDLE:**
  - `start`=1 latches `n_pass`, `n_out` (clamped) and `relu_en`, clears `err`, and moves to ACCUM.
  - If the latched `n_pass`=0 or `n_out`=0, the FSM goes to IDLE instead and pulses `done` next cycle with no output rows.
- **ACCUM, per lane c:**
  - Each lane keeps a row pointer `wptr[c]` and a pass counter `pcnt[c]`.
  - On `in_valid[c]` the element write is `buf[wptr[c]][c] <= (pcnt[c]==0) ? in : buf[wptr[c]][c] + in`.
  - `wptr[c]` then increments. When it reaches `n_out` it wraps to 0 and `pcnt[c]` increments.
  - Because lanes are independent, lane 0 may start pass k+1 while lane 7 is still in pass k.
  - A lane with `pcnt[c]==n_pass` is finished. Further `in_valid[c]` on a finished lane is dropped and sets `err`.
  - When all lanes are finished, the FSM moves to DRAIN.
- **DRAIN:**
  - Read pointer `rptr` starts at 0.
  - `out_data` lane c = `buf[rptr][c]`, forced to 0 if `relu_en` and the value is negative.
  - `out_valid`=1 throughout DRAIN.
  - Each cycle with `out_valid && out_ready` advances `rptr`.
  - On the handshake at `rptr==n_out-1`, the FSM goes to IDLE and pulses `done`.
- **Arithmetic:** signed two's complement at `psum_bw` bits; the overflow rule is set by the Configuration macro.
- **Boundary conditions:**
  - `start` while `busy` is ignored.
  - `in_valid` outside ACCUM is dropped and sets `err`.
  - `out_ready` outside DRAIN is ignored.
  - Reset mid-job aborts immediately to the reset values; no `done`.

## Timing
- `start` sampled at edge S gives `busy`=1 from S+1; `in_valid` is accepted from S+1.
- Accumulation latency is one cycle: an element is written at the edge that samples its `in_valid`.
- If the final lane's last element is written at edge T, then DRAIN and `out_valid` are active from T+1 and the row shows the final value.
- `out_data` is stable while `out_valid && !out_ready`.
- Full-rate drain: `n_out` rows take `n_out` cycles with `out_ready` held 1.
- `done` is high for exactly the cycle after the last handshake, with `busy`=0 in that same cycle.
- The next `start` is accepted in the `done` cycle.

## Configuration
- **`CORELET_ACCUM_SAT_EN` defined:**
  - The accumulate add saturates to +2^(psum_bw-1)-1 / -2^(psum_bw-1).
  - Any saturation event also sets `err`.
- **Undefined:** the add wraps modulo 2^psum_bw, with no `err` from overflow.

## Test plan
- **Basic 1-pass job:**
  - Setup: `n_pass`=1, `n_out`=4.
  - Stimulus: all lanes `in_valid` together with lane c row r = 10*r+c.
  - Response: rows emerge r=0..3 with identical values, `out_valid` from T+1, `done` 1 cycle after the 4th handshake.
- **Staggered 3-pass job:**
  - Setup: `n_pass`=3, `n_out`=2.
  - Stimulus: lane c delayed c cycles, input 5 every time.
  - Response: every drained element = 15; lane 0 starts pass 2 before lane 7 finishes pass 1 without corruption.
- **ReLU:**
  - Setup: `relu_en`=1.
  - Stimulus: inputs -7 then +3 over 2 passes.
  - Response: output 0 (sum -4).
  - Repeat with inputs +9 and -2: output 7.
  - With `relu_en`=0, -4 passes through.
- **Backpressure:**
  - Stimulus: `out_ready` toggles 1,0,0,1 during drain.
  - Response: `out_data` is held while stalled, and no row is skipped or duplicated.
- **Overflow:**
  - Setup: psum_bw=16.
  - Stimulus: add 30000+30000.
  - Response: 32767 and `err`=1 with `CORELET_ACCUM_SAT_EN`; -5536 and `err`=0 without.
- **Error/abort:**
  - Extra `in_valid[2]` after lane 2 finishes gives `err`=1 while other rows are unchanged.
  - `reset` mid-DRAIN gives `out_valid`=0 and IDLE the next cycle, with no `done`.

Source files
------------

// File: rtl/corelet_accum_if.sv
// Handshake and data bundle between the corelet MAC array, the accumulate back-end,
// and the output consumer.
interface corelet_accum_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int pass_bw = 8
);
  localparam int ow = $clog2(depth) + 1;

  logic                     start;
  logic [pass_bw-1:0]       n_pass;
  logic [ow-1:0]            n_out;
  logic                     relu_en;
  logic [col*psum_bw-1:0]   in_psum;
  logic [col-1:0]           in_valid;
  // Output row moves on any rising edge where out_valid && out_ready.
  // out_data is held while out_valid && !out_ready; there is no input back-pressure.
  logic [col*psum_bw-1:0]   out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    output start, n_pass, n_out, relu_en, in_psum, in_valid, out_ready,
    input  out_data, out_valid, busy, done, err
  );

  modport slave (
    input  start, n_pass, n_out, relu_en, in_psum, in_valid, out_ready,
    output out_data, out_valid, busy, done, err
  );
endinterface

// File: rtl/corelet_accum.sv
// Multi-pass per-lane psum accumulator with aligned, optionally ReLU'd row drain.
// Build option: define CORELET_ACCUM_SAT_EN for saturating adds (otherwise adds wrap).
module corelet_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int pass_bw = 8
) (
  input  logic       clk,
  input  logic       reset,
  corelet_accum_if.slave bus,
  output logic [1:0] fsm_state
);
  localparam int ow = $clog2(depth) + 1;
  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                state;
  logic [pass_bw-1:0]        npass_q;
  logic [ow-1:0]             nout_q;
  logic                      relu_q;
  logic [ow-1:0]             wptr [col];
  logic [pass_bw-1:0]        pcnt [col];
  logic [ow-1:0]             rptr;
  logic [psum_bw-1:0]        mem [depth][col];

  logic [ow-1:0]             nout_clamp;
  logic [col-1:0]            lane_fin, lane_wr, lane_last, lane_drop, sat_hit;
  logic [psum_bw-1:0]        wval [col];
  logic                      all_done, start_acc, err_set;

  assign fsm_state  = state;
  assign nout_clamp = (bus.n_out > ow'(depth)) ? ow'(depth) : bus.n_out;
  assign start_acc  = (state == S_IDLE) && bus.start;

  always_comb begin
    for (int c = 0; c < col; c++) begin
      logic [psum_bw-1:0] in_v, old_v;
      logic [psum_bw:0]   wide;
      in_v   = bus.in_psum[c*psum_bw +: psum_bw];
      old_v  = mem[wptr[c][aw-1:0]][c];
      wide   = {old_v[psum_bw-1], old_v} + {in_v[psum_bw-1], in_v};
      lane_fin[c]  = (pcnt[c] == npass_q);
      lane_wr[c]   = (state == S_ACCUM) && bus.in_valid[c] && !lane_fin[c];
      lane_last[c] = lane_wr[c] && (wptr[c] == nout_q - ow'(1)) &&
                     (pcnt[c] == npass_q - pass_bw'(1));
      lane_drop[c] = bus.in_valid[c] && ((state != S_ACCUM) || lane_fin[c]);
      sat_hit[c]   = 1'b0;
      wval[c]      = wide[psum_bw-1:0];
`ifdef CORELET_ACCUM_SAT_EN
      // Sign of the extended sum disagrees with the truncated one: clamp.
      if (wide[psum_bw] != wide[psum_bw-1]) begin
        wval[c]    = wide[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        sat_hit[c] = lane_wr[c] && (pcnt[c] != '0);
      end
`endif
      if (pcnt[c] == '0) wval[c] = in_v;
    end
  end

  assign all_done = &(lane_fin | lane_last);
  assign err_set  = (|lane_drop) | (|sat_hit);

  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++)
      if (lane_wr[c]) mem[wptr[c][aw-1:0]][c] <= wval[c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      npass_q <= '0;
      nout_q  <= '0;
      relu_q  <= 1'b0;
      rptr    <= '0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      for (int c = 0; c < col; c++) begin
        wptr[c] <= '0;
        pcnt[c] <= '0;
      end
    end else begin
      bus.done <= 1'b0;
      bus.err  <= (start_acc ? 1'b0 : bus.err) | err_set;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            npass_q <= bus.n_pass;
            nout_q  <= nout_clamp;
            relu_q  <= bus.relu_en;
            rptr    <= '0;
            for (int c = 0; c < col; c++) begin
              wptr[c] <= '0;
              pcnt[c] <= '0;
            end
            // Empty job: finish immediately without visiting ACCUM/DRAIN.
            if (bus.n_pass == '0 || nout_clamp == '0) bus.done <= 1'b1;
            else                                       state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int c = 0; c < col; c++) begin
            if (lane_wr[c]) begin
              if (wptr[c] == nout_q - ow'(1)) begin
                wptr[c] <= '0;
                pcnt[c] <= pcnt[c] + pass_bw'(1);
              end else begin
                wptr[c] <= wptr[c] + ow'(1);
              end
            end
          end
          if (all_done) begin
            state <= S_DRAIN;
            rptr  <= '0;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (rptr == nout_q - ow'(1)) begin
              state    <= S_IDLE;
              rptr     <= '0;
              bus.done <= 1'b1;
            end else begin
              rptr <= rptr + ow'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_ACCUM) || (state == S_DRAIN);
  assign bus.out_valid = (state == S_DRAIN);

  always_comb begin
    bus.out_data = '0;
    for (int c = 0; c < col; c++) begin
      logic [psum_bw-1:0] v;
      v = mem[rptr[aw-1:0]][c];
      if (relu_q && v[psum_bw-1]) v = '0;
      if (state == S_DRAIN) bus.out_data[c*psum_bw +: psum_bw] = v;
    end
  end
endmodule

// File: tb/tb_corelet_accum.sv
// Self-checking bench for corelet_accum: table-driven jobs plus hand-written corner sequences,
// with drained rows checked against an expected-row queue.
module tb_corelet_accum;
  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int DEP = 16;
  localparam int PSB = 8;
  localparam int W   = COL * PBW;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] fsm_state;

  corelet_accum_if #(.col(COL), .psum_bw(PBW), .depth(DEP), .pass_bw(PSB)) bus ();

  corelet_accum #(.col(COL), .psum_bw(PBW), .depth(DEP), .pass_bw(PSB)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          np;
    int          no;
    int          rows;
    bit          relu;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_val;
    bit          exp_err;
  } vec_t;

  vec_t           tbl[6];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = v;
    return r;
  endfunction

  task automatic start_job(input int np, input int no, input bit relu);
    bus.start   = 1'b1;
    bus.n_pass  = PSB'(np);
    bus.n_out   = 5'(no);
    bus.relu_en = relu;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic send_rows(input int rows, input logic [15:0] v, input logic [COL-1:0] mask);
    for (int r = 0; r < rows; r++) begin
      bus.in_valid = mask;
      bus.in_psum  = rep(v);
      @(negedge clk);
    end
    bus.in_valid = '0;
  endtask

  task automatic drain(input int mode, input int rows);
    int           got;
    int           cyc;
    bit           stalled;
    logic [W-1:0] prev;
    logic [W-1:0] e;
    got = 0; cyc = 0; stalled = 0; prev = '0;
    while (got < rows && cyc < 200) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      chk("out_valid", bus.out_valid, 1);
      if (stalled) chk("stall_hold", bus.out_data, prev);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow act=extra_row exp=none");
        end else begin
          e = exp_q.pop_front();
          chk("row", bus.out_data, e);
        end
        got++;
        stalled = 0;
      end else begin
        stalled = bus.out_valid;
        prev    = bus.out_data;
      end
      cyc++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    if (got < rows) begin
      checks++; errors++;
      $display("FAIL drain_timeout act=%0d exp=%0d", got, rows);
    end
    if (mode == 0) chk("full_rate", cyc, rows);
    chk("done_pulse", bus.done, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("sb_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{np: 2, no: 1,  rows: 1,  relu: 1, a: -16'sd7,   b: 16'sd3,    exp_val: 16'sd0,    exp_err: 0};
    tbl[1] = '{np: 2, no: 1,  rows: 1,  relu: 1, a: 16'sd9,    b: -16'sd2,   exp_val: 16'sd7,    exp_err: 0};
    tbl[2] = '{np: 2, no: 1,  rows: 1,  relu: 0, a: -16'sd7,   b: 16'sd3,    exp_val: -16'sd4,   exp_err: 0};
`ifdef CORELET_ACCUM_SAT_EN
    tbl[3] = '{np: 2, no: 2,  rows: 2,  relu: 0, a: 16'sd30000, b: 16'sd30000, exp_val: 16'h7fff, exp_err: 1};
`else
    tbl[3] = '{np: 2, no: 2,  rows: 2,  relu: 0, a: 16'sd30000, b: 16'sd30000, exp_val: 16'hea60, exp_err: 0};
`endif
    tbl[4] = '{np: 1, no: 31, rows: 16, relu: 0, a: -16'sd100, b: 16'sd0,    exp_val: -16'sd100, exp_err: 0};
    tbl[5] = '{np: 1, no: 3,  rows: 3,  relu: 1, a: -16'sd1,   b: 16'sd0,    exp_val: 16'sd0,    exp_err: 0};

    reset = 1'b1;
    bus.start = 0; bus.n_pass = '0; bus.n_out = '0; bus.relu_en = 0;
    bus.in_psum = '0; bus.in_valid = '0; bus.out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_state", fsm_state, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic one-pass job: lane c row r = 10*r + c
    start_job(1, 4, 0);
    chk("busy_after_start", bus.busy, 1);
    for (int r = 0; r < 4; r++) begin
      logic [W-1:0] row;
      for (int c = 0; c < COL; c++) row[c*PBW +: PBW] = PBW'(10*r + c);
      exp_q.push_back(row);
      bus.in_valid = '1;
      bus.in_psum  = row;
      @(negedge clk);
    end
    bus.in_valid = '0;
    chk("basic_drain_T1", bus.out_valid, 1);
    drain(0, 4);
    chk("basic_err", bus.err, 0);

    // Table-driven jobs
    for (int i = 0; i < 6; i++) begin
      start_job(tbl[i].np, tbl[i].no, tbl[i].relu);
      for (int r = 0; r < tbl[i].rows; r++) exp_q.push_back(rep(tbl[i].exp_val));
      send_rows(tbl[i].rows, tbl[i].a, '1);
      if (tbl[i].np == 2) send_rows(tbl[i].rows, tbl[i].b, '1);
      chk("tbl_drain_start", bus.out_valid, 1);
      drain(0, tbl[i].rows);
      chk("tbl_err", bus.err, tbl[i].exp_err);
    end

    // Staggered 3-pass job, lane c delayed c cycles
    start_job(3, 2, 0);
    chk("stag_err_cleared", bus.err, 0);
    exp_q.push_back(rep(16'sd15));
    exp_q.push_back(rep(16'sd15));
    for (int t = 0; t < 13; t++) begin
      for (int c = 0; c < COL; c++) bus.in_valid[c] = (t >= c) && (t - c < 6);
      bus.in_psum = rep(16'sd5);
      if (t == 12) chk("stag_still_accum", fsm_state, 1);
      @(negedge clk);
    end
    bus.in_valid = '0;
    chk("stag_drain_T1", bus.out_valid, 1);
    drain(0, 2);

    // Backpressure with ready pattern 1,0,0,1
    start_job(1, 4, 0);
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back(rep(16'(r*100 + 1)));
      bus.in_valid = '1;
      bus.in_psum  = rep(16'(r*100 + 1));
      @(negedge clk);
    end
    bus.in_valid = '0;
    drain(1, 4);

    // Extra element on a finished lane
    start_job(1, 2, 0);
    send_rows(2, 16'sd4, 8'b0000_0100);
    send_rows(1, 16'sd99, 8'b0000_0100);
    chk("extra_lane_err", bus.err, 1);
    chk("extra_lane_accum", fsm_state, 1);
    exp_q.push_back(rep(16'sd4));
    exp_q.push_back(rep(16'sd4));
    send_rows(2, 16'sd4, 8'b1111_1011);
    drain(0, 2);
    chk("err_sticky", bus.err, 1);

    // in_valid in IDLE sets err after a clean start
    start_job(0, 3, 0);
    chk("zero_pass_done", bus.done, 1);
    chk("zero_pass_busy", bus.busy, 0);
    chk("zero_pass_err_clear", bus.err, 0);
    @(negedge clk);
    chk("zero_pass_no_rows", bus.out_valid, 0);
    send_rows(1, 16'sd1, '1);
    chk("idle_valid_err", bus.err, 1);

    // start while busy is ignored; out_ready outside DRAIN is ignored
    start_job(1, 2, 0);
    bus.out_ready = 1'b1;
    start_job(5, 1, 1);
    bus.out_ready = 1'b0;
    chk("start_busy_ignored", fsm_state, 1);
    exp_q.push_back(rep(-16'sd3));
    exp_q.push_back(rep(-16'sd3));
    send_rows(2, -16'sd3, '1);
    drain(0, 2);

    // Reset in the middle of a drain
    start_job(1, 4, 0);
    for (int r = 0; r < 4; r++) exp_q.push_back(rep(16'sd8));
    send_rows(4, 16'sd8, '1);
    bus.out_ready = 1'b1;
    chk("abort_row0", bus.out_data, exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_state", fsm_state, 0);
    chk("abort_done", bus.done, 0);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_no_done", bus.done, 0);
    chk("abort_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
